// File: rtl/mac_result_drain.sv
// Result drain for one row of MAC PEs: snapshots every accumulator on capture,
// clears the row, then streams the words out one per valid/ready handshake, saturated.
module mac_result_drain #(
    parameter int DATAWIDTH = 14,
    parameter int NUM_PE    = 4,
    parameter int OUT_WIDTH = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            capture,
    input  logic [NUM_PE*2*DATAWIDTH-1:0]   acc_in,
    output logic                            acc_clear,
    output logic                            busy,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [OUT_WIDTH-1:0]            out_data,
    output logic [$clog2(NUM_PE)-1:0]       out_idx,
    output logic                            out_last,
    output logic                            sat_flag,
    output logic                            done,
    output logic                            capture_drop
);

    localparam int AW = 2 * DATAWIDTH;
    localparam int IW = $clog2(NUM_PE);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_PE - 1);
    localparam logic [AW-1:0] MAX_OUT  = AW'({OUT_WIDTH{1'b1}});

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Clip to the output range; the MSB of the result is the clip flag.
    function automatic logic [OUT_WIDTH:0] sat_word(input logic [AW-1:0] x);
        logic [OUT_WIDTH:0] res_s;
        if (x > MAX_OUT) begin
            res_s = {1'b1, {OUT_WIDTH{1'b1}}};
        end else begin
            res_s = {1'b0, x[OUT_WIDTH-1:0]};
        end
        return res_s;
    endfunction

    state_t              state_r;
    state_t              state_nxt_s;
    logic [IW-1:0]       idx_r;
    logic [IW-1:0]       idx_nxt_s;
    logic [AW-1:0]       shadow_r [NUM_PE];
    logic                load_s;
    logic                drop_nxt_s;
    logic [AW-1:0]       sel_word_s;
    logic [OUT_WIDTH:0]  sat_s;
    logic                stream_nxt_s;

    logic                acc_clear_r;
    logic                busy_r;
    logic                out_valid_r;
    logic [OUT_WIDTH-1:0] out_data_r;
    logic [IW-1:0]       out_idx_r;
    logic                out_last_r;
    logic                sat_flag_r;
    logic                done_r;
    logic                capture_drop_r;

    // Next-state, index advance and capture acceptance/drop decisions.
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        load_s      = 1'b0;
        drop_nxt_s  = capture_drop_r;
        case (state_r)
            IDLE: begin
                if (capture) begin
                    state_nxt_s = STREAM;
                    idx_nxt_s   = {IW{1'b0}};
                    load_s      = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            STREAM: begin
                if (capture) begin
                    drop_nxt_s = 1'b1;
                end else begin
                    drop_nxt_s = capture_drop_r;
                end
                if (out_ready) begin
                    if (idx_r == LAST_IDX) begin
                        state_nxt_s = DONE;
                    end else begin
                        idx_nxt_s = idx_r + {{(IW-1){1'b0}}, 1'b1};
                    end
                end else begin
                    idx_nxt_s = idx_r;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
                if (capture) begin
                    drop_nxt_s = 1'b1;
                end else begin
                    drop_nxt_s = capture_drop_r;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                idx_nxt_s   = {IW{1'b0}};
            end
        endcase
    end

    // Word presented next cycle: the fresh acc_in word on a capture, else the shadow slot.
    always_comb begin
        if (load_s) begin
            sel_word_s = acc_in[AW-1:0];
        end else begin
            sel_word_s = shadow_r[idx_nxt_s];
        end
        sat_s        = sat_word(sel_word_s);
        stream_nxt_s = (state_nxt_s == STREAM);
    end

    // State, index and snapshot registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            idx_r   <= {IW{1'b0}};
            for (int i = 0; i < NUM_PE; i++) begin
                shadow_r[i] <= {AW{1'b0}};
            end
        end else begin
            state_r <= state_nxt_s;
            idx_r   <= idx_nxt_s;
            if (load_s) begin
                for (int i = 0; i < NUM_PE; i++) begin
                    shadow_r[i] <= acc_in[i*AW +: AW];
                end
            end
        end
    end

    // Output registers, loaded from next-state values so they line up with the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_clear_r    <= 1'b0;
            busy_r         <= 1'b0;
            out_valid_r    <= 1'b0;
            out_data_r     <= {OUT_WIDTH{1'b0}};
            out_idx_r      <= {IW{1'b0}};
            out_last_r     <= 1'b0;
            sat_flag_r     <= 1'b0;
            done_r         <= 1'b0;
            capture_drop_r <= 1'b0;
        end else begin
            acc_clear_r    <= load_s;
            busy_r         <= (state_nxt_s != IDLE);
            out_valid_r    <= stream_nxt_s;
            out_data_r     <= stream_nxt_s ? sat_s[OUT_WIDTH-1:0] : {OUT_WIDTH{1'b0}};
            out_idx_r      <= stream_nxt_s ? idx_nxt_s : {IW{1'b0}};
            out_last_r     <= stream_nxt_s && (idx_nxt_s == LAST_IDX);
            sat_flag_r     <= stream_nxt_s && sat_s[OUT_WIDTH];
            done_r         <= (state_nxt_s == DONE);
            capture_drop_r <= drop_nxt_s;
        end
    end

    assign acc_clear    = acc_clear_r;
    assign busy         = busy_r;
    assign out_valid    = out_valid_r;
    assign out_data     = out_data_r;
    assign out_idx      = out_idx_r;
    assign out_last     = out_last_r;
    assign sat_flag     = sat_flag_r;
    assign done         = done_r;
    assign capture_drop = capture_drop_r;

endmodule

// File: tb/tb_mac_result_drain.sv
// Bench for mac_result_drain: vector table of full drains, hand-written stall/drop/reset
// sequences, and a random phase checked against a queue-based transaction model.
module tb_mac_result_drain;

    localparam int DW  = 14;
    localparam int NPE = 4;
    localparam int OW  = 16;
    localparam int AW  = 2 * DW;
    localparam int IW  = 2;

    logic                 clk;
    logic                 reset;
    logic                 capture;
    logic [NPE*AW-1:0]    acc_in;
    logic                 acc_clear;
    logic                 busy;
    logic                 out_valid;
    logic                 out_ready;
    logic [OW-1:0]        out_data;
    logic [IW-1:0]        out_idx;
    logic                 out_last;
    logic                 sat_flag;
    logic                 done;
    logic                 capture_drop;

    int n_cmp = 0;
    int n_bad = 0;

    mac_result_drain #(.DATAWIDTH(DW), .NUM_PE(NPE), .OUT_WIDTH(OW)) dut (
        .clk(clk), .reset(reset), .capture(capture), .acc_in(acc_in),
        .acc_clear(acc_clear), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_idx(out_idx), .out_last(out_last), .sat_flag(sat_flag),
        .done(done), .capture_drop(capture_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [NPE-1:0][AW-1:0] acc;
        logic [NPE-1:0][OW-1:0] exp_d;
        logic [NPE-1:0]         exp_s;
    } vec_t;

    typedef struct {
        logic [OW-1:0] d;
        logic          s;
        int            idx;
    } word_t;

    vec_t  tbl [4];
    word_t q [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] outs_packed();
        return {39'd0, acc_clear, busy, out_valid, out_data, out_idx, out_last,
                sat_flag, done, capture_drop};
    endfunction

    function automatic logic [NPE*AW-1:0] rand_acc();
        logic [NPE*AW-1:0] r;
        for (int i = 0; i < NPE; i++) begin
            if ($urandom_range(0, 1) == 1) r[i*AW +: AW] = AW'($urandom_range(0, 70000));
            else                           r[i*AW +: AW] = AW'($urandom());
        end
        return r;
    endfunction

    // Full drain with out_ready held high; acc_in is scrambled right after the capture edge.
    task automatic run_vec(input vec_t v);
        acc_in    = v.acc;
        capture   = 1'b1;
        out_ready = 1'b1;
        tick();
        capture = 1'b0;
        acc_in  = rand_acc();
        for (int i = 0; i < NPE; i++) begin
            chk("vec_valid", {63'd0, out_valid}, 64'd1);
            chk("vec_busy", {63'd0, busy}, 64'd1);
            chk("vec_acc_clear", {63'd0, acc_clear}, (i == 0) ? 64'd1 : 64'd0);
            chk("vec_data", {48'd0, out_data}, {48'd0, v.exp_d[i]});
            chk("vec_sat", {63'd0, sat_flag}, {63'd0, v.exp_s[i]});
            chk("vec_idx", {62'd0, out_idx}, 64'(i));
            chk("vec_last", {63'd0, out_last}, (i == NPE - 1) ? 64'd1 : 64'd0);
            chk("vec_done_early", {63'd0, done}, 64'd0);
            tick();
        end
        chk("vec_done", {63'd0, done}, 64'd1);
        chk("vec_valid_off", {63'd0, out_valid}, 64'd0);
        tick();
        chk("vec_done_pulse", {63'd0, done}, 64'd0);
        chk("vec_idle", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic          clear_pend;
        logic          done_pend;
        logic          drop_m;
        logic          idle_m;
        logic          new_done;
        logic          new_clear;
        logic [AW-1:0] x;
        word_t         w;

        tbl[0].acc   = {28'd400, 28'd300, 28'd200, 28'd100};
        tbl[0].exp_d = {16'd400, 16'd300, 16'd200, 16'd100};
        tbl[0].exp_s = 4'b0000;
        tbl[1].acc   = {28'd1, 28'd0, 28'd65535, 28'd70000};
        tbl[1].exp_d = {16'd1, 16'd0, 16'd65535, 16'd65535};
        tbl[1].exp_s = 4'b0001;
        tbl[2].acc   = {28'd65534, 28'd12345, 28'd65536, 28'hFFFFFFF};
        tbl[2].exp_d = {16'd65534, 16'd12345, 16'hFFFF, 16'hFFFF};
        tbl[2].exp_s = 4'b0011;
        tbl[3].acc   = {NPE*AW{1'b0}};
        tbl[3].exp_d = {NPE*OW{1'b0}};
        tbl[3].exp_s = 4'b0000;

        // T1: reset held with random inputs, then idle after release
        reset     = 1'b0;
        capture   = 1'b0;
        out_ready = 1'b0;
        acc_in    = {NPE*AW{1'b0}};
        for (int c = 0; c < 5; c++) begin
            capture   = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            acc_in    = rand_acc();
            tick();
            chk("reset_outs", outs_packed(), 64'd0);
        end
        capture   = 1'b0;
        out_ready = 1'b1;
        reset     = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("post_reset_busy", {63'd0, busy}, 64'd0);
            chk("post_reset_valid", {63'd0, out_valid}, 64'd0);
        end

        // T2/T4: vector table of full drains
        for (int k = 0; k < 4; k++) begin
            run_vec(tbl[k]);
        end

        // T3: stall on word 200 for three cycles
        acc_in    = tbl[0].acc;
        capture   = 1'b1;
        out_ready = 1'b1;
        tick();
        capture = 1'b0;
        chk("stall_w0", {48'd0, out_data}, 64'd100);
        tick();
        for (int j = 0; j < 4; j++) begin
            chk("stall_hold_data", {48'd0, out_data}, 64'd200);
            chk("stall_hold_idx", {62'd0, out_idx}, 64'd1);
            chk("stall_hold_valid", {63'd0, out_valid}, 64'd1);
            out_ready = (j == 3);
            tick();
        end
        chk("stall_next_data", {48'd0, out_data}, 64'd300);
        chk("stall_next_idx", {62'd0, out_idx}, 64'd2);
        tick();
        chk("stall_last_data", {48'd0, out_data}, 64'd400);
        chk("stall_last_flag", {63'd0, out_last}, 64'd1);
        tick();
        chk("stall_done", {63'd0, done}, 64'd1);
        tick();

        // T5: captures during STREAM and DONE are dropped
        acc_in  = {28'd44, 28'd33, 28'd22, 28'd11};
        capture = 1'b1;
        tick();
        capture = 1'b0;
        chk("drop_w0", {48'd0, out_data}, 64'd11);
        chk("drop_flag_clear", {63'd0, capture_drop}, 64'd0);
        tick();
        chk("drop_w1", {48'd0, out_data}, 64'd22);
        capture = 1'b1;
        acc_in  = rand_acc();
        tick();
        capture = 1'b0;
        chk("drop_w2", {48'd0, out_data}, 64'd33);
        chk("drop_w2_idx", {62'd0, out_idx}, 64'd2);
        chk("drop_no_clear", {63'd0, acc_clear}, 64'd0);
        chk("drop_flag_set", {63'd0, capture_drop}, 64'd1);
        tick();
        chk("drop_w3", {48'd0, out_data}, 64'd44);
        chk("drop_w3_last", {63'd0, out_last}, 64'd1);
        tick();
        chk("drop_done", {63'd0, done}, 64'd1);
        capture = 1'b1;
        tick();
        capture = 1'b0;
        chk("drop_done_busy", {63'd0, busy}, 64'd0);
        chk("drop_done_valid", {63'd0, out_valid}, 64'd0);
        chk("drop_done_clear", {63'd0, acc_clear}, 64'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("drop_sticky", {63'd0, capture_drop}, 64'd1);
            chk("drop_idle", {63'd0, busy}, 64'd0);
        end

        // T6: asynchronous reset mid-stream at idx2
        acc_in  = {28'd8, 28'd7, 28'd6, 28'd5};
        capture = 1'b1;
        tick();
        capture = 1'b0;
        tick();
        tick();
        chk("mid_idx2", {62'd0, out_idx}, 64'd2);
        chk("mid_data", {48'd0, out_data}, 64'd7);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_reset_async", outs_packed(), 64'd0);
        tick();
        chk("mid_reset_no_done", outs_packed(), 64'd0);
        reset = 1'b1;
        run_vec(tbl[2]);

        // Random phase against the transaction model
        q.delete();
        clear_pend = 1'b0;
        done_pend  = 1'b0;
        drop_m     = 1'b0;
        for (int c = 0; c < 600; c++) begin
            chk("rnd_valid", {63'd0, out_valid}, (q.size() > 0) ? 64'd1 : 64'd0);
            chk("rnd_busy", {63'd0, busy}, (q.size() > 0 || done_pend) ? 64'd1 : 64'd0);
            chk("rnd_clear", {63'd0, acc_clear}, {63'd0, clear_pend});
            chk("rnd_done", {63'd0, done}, {63'd0, done_pend});
            chk("rnd_drop", {63'd0, capture_drop}, {63'd0, drop_m});
            if (q.size() > 0) begin
                chk("rnd_data", {48'd0, out_data}, {48'd0, q[0].d});
                chk("rnd_sat", {63'd0, sat_flag}, {63'd0, q[0].s});
                chk("rnd_idx", {62'd0, out_idx}, 64'(q[0].idx));
                chk("rnd_last", {63'd0, out_last}, (q[0].idx == NPE - 1) ? 64'd1 : 64'd0);
            end
            capture   = ($urandom_range(0, 7) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            acc_in    = rand_acc();

            idle_m    = (q.size() == 0) && !done_pend;
            new_done  = 1'b0;
            new_clear = 1'b0;
            if (q.size() > 0 && out_ready) begin
                void'(q.pop_front());
                if (q.size() == 0) new_done = 1'b1;
            end
            if (capture) begin
                if (idle_m) begin
                    for (int i = 0; i < NPE; i++) begin
                        x = acc_in[i*AW +: AW];
                        if (64'(x) > ((64'd1 << OW) - 64'd1)) begin
                            w.d = {OW{1'b1}};
                            w.s = 1'b1;
                        end else begin
                            w.d = x[OW-1:0];
                            w.s = 1'b0;
                        end
                        w.idx = i;
                        q.push_back(w);
                    end
                    new_clear = 1'b1;
                end else begin
                    drop_m = 1'b1;
                end
            end
            done_pend  = new_done;
            clear_pend = new_clear;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
